ps2_mouse_tracker: RTL and testbench

//  Parametrised PS/2 mouse tracker: initialises the mouse (reset, enable streaming), assembles 3-byte movement packets,

---
 rtl/ps2_mouse_tracker_pkg.sv | 34 +++
 rtl/ps2_axis_accum.sv | 52 +++++
 rtl/ps2_mouse_tracker.sv | 199 +++++++++++++++++++
 tb/tb_ps2_mouse_tracker.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_mouse_tracker_pkg.sv
// Shared constants, FSM state encoding and small helpers for the PS/2 mouse tracker.
package ps2_mouse_tracker_pkg;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT    = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  typedef enum logic [2:0] {
    S_RST_SEND = 3'd0,
    S_RST_ACK  = 3'd1,
    S_BAT      = 3'd2,
    S_ID       = 3'd3,
    S_EN_SEND  = 3'd4,
    S_EN_ACK   = 3'd5,
    S_STREAM   = 3'd6,
    S_ERROR    = 3'd7
  } state_e;

  // Byte that moves each init wait state forward.
  function automatic logic [7:0] expected_rsp(input state_e s);
    case (s)
      S_BAT:   return RSP_BAT;
      S_ID:    return RSP_ID;
      default: return RSP_ACK;
    endcase
  endfunction

  function automatic logic signed [8:0] sext9(input logic sign, input logic [7:0] low);
    return {sign, low};
  endfunction

endpackage

// File: rtl/ps2_axis_accum.sv
// One cursor axis: masks overflowed deltas, scales, adds (or subtracts) and clamps to 0..MAX.
module ps2_axis_accum
  import ps2_mouse_tracker_pkg::*;
#(
  parameter int POS_W  = 8,
  parameter int MAX    = 159,
  parameter int INIT   = 80,
  parameter int SHIFT  = 0,
  parameter int INVERT = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             reinit_i,
  input  logic             sign_i,
  input  logic             ovf_i,
  input  logic [7:0]       low_i,
  output logic [POS_W-1:0] pos_o
);

  // Wide enough for 0..2^POS_W-1 plus any 9-bit signed delta without wrap.
  localparam int SW = (POS_W + 2 > 10) ? POS_W + 2 : 10;
  localparam logic signed [SW-1:0] MAX_S = SW'(MAX);

  logic [POS_W-1:0]     pos_q, pos_d;
  logic signed [8:0]    d_raw, d_sh;
  logic signed [SW-1:0] d_ext, pos_ext, sum;

  always_comb begin
    d_raw   = sext9(sign_i, low_i);
    d_sh    = ovf_i ? 9'sd0 : (d_raw >>> SHIFT);
    d_ext   = {{(SW-9){d_sh[8]}}, d_sh};
    pos_ext = {{(SW-POS_W){1'b0}}, pos_q};
    sum     = (INVERT != 0) ? (pos_ext - d_ext) : (pos_ext + d_ext);
    pos_d   = pos_q;
    if (reinit_i) begin
      pos_d = POS_W'(INIT);
    end else if (load_i) begin
      if (sum < 0)           pos_d = '0;
      else if (sum > MAX_S)  pos_d = POS_W'(MAX);
      else                   pos_d = sum[POS_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pos_q <= POS_W'(INIT);
    else         pos_q <= pos_d;
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse tracker: init handshake with retries, 3-byte packet assembly, clamped cursor and buttons.
// Handshake: rx_en/cmd_sent/cmd_err are single-cycle strobes; cmd_send pulses once with cmd already stable.
module ps2_mouse_tracker
  import ps2_mouse_tracker_pkg::*;
#(
  parameter int X_MAX       = 159,
  parameter int Y_MAX       = 119,
  parameter int X_INIT      = 80,
  parameter int Y_INIT      = 60,
  parameter int POS_W       = 8,
  parameter int SHIFT       = 0,
  parameter int ACK_TIMEOUT = 25000000,
  parameter int GAP_TIMEOUT = 100000,
  parameter int MAX_RETRY   = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [7:0]       rx_data,
  input  logic             rx_en,
  input  logic             cmd_sent,
  input  logic             cmd_err,
  output logic [7:0]       cmd,
  output logic             cmd_send,
  output logic [POS_W-1:0] x_pos,
  output logic [POS_W-1:0] y_pos,
  output logic [2:0]       buttons,
  output logic             left_click,
  output logic             pkt_valid,
  output logic             ready,
  output logic             init_error,
  output logic [3:0]       dbg_fsm
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  state_e          state_q, state_d, nxt;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      flags_q, flags_d, dxl_q, dxl_d, cmd_q, cmd_d;
  logic [2:0]      buttons_q, buttons_d;
  logic            saw_aa_q, saw_aa_d, cmd_send_q, cmd_send_d, cmd_done_q, cmd_done_d;
  logic            click_q, click_d, pkt_q, pkt_d;
  logic            wait_st, tmo_hit, upd, reinit;

  always_comb begin
    state_d    = state_q;
    nxt        = state_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    retry_d    = retry_q;
    idx_d      = idx_q;
    flags_d    = flags_q;
    dxl_d      = dxl_q;
    saw_aa_d   = saw_aa_q;
    cmd_d      = cmd_q;
    cmd_send_d = 1'b0;
    cmd_done_d = cmd_done_q | cmd_sent;
    buttons_d  = buttons_q;
    click_d    = 1'b0;
    pkt_d      = 1'b0;
    upd        = 1'b0;
    reinit     = 1'b0;
    wait_st    = 1'b0;
    tmo_hit    = (tmo_q == TMO_LAST) && !rx_en;

    case (state_q)
      S_RST_SEND: begin
        cmd_d = CMD_RESET; cmd_send_d = 1'b1; cmd_done_d = 1'b0; state_d = S_RST_ACK;
      end
      S_RST_ACK: begin wait_st = 1'b1; nxt = S_BAT;     end
      S_BAT:     begin wait_st = 1'b1; nxt = S_ID;      end
      S_ID:      begin wait_st = 1'b1; nxt = S_EN_SEND; end
      S_EN_SEND: begin
        cmd_d = CMD_ENABLE; cmd_send_d = 1'b1; cmd_done_d = 1'b0; state_d = S_EN_ACK;
      end
      S_EN_ACK:  begin wait_st = 1'b1; nxt = S_STREAM;  end
      S_STREAM: begin
        if (rx_en) begin
          gap_d    = '0;
          saw_aa_d = 1'b0;
          // AA then 00 is a freshly plugged mouse finishing its self-test.
          if (saw_aa_q && rx_data == RSP_ID) begin
            reinit    = 1'b1;
            buttons_d = '0;
            state_d   = S_EN_SEND;
          end else begin
            case (idx_q)
              2'd0: if (rx_data[3]) begin
                flags_d  = rx_data;
                idx_d    = 2'd1;
                saw_aa_d = (rx_data == RSP_BAT);
              end
              2'd1: begin dxl_d = rx_data; idx_d = 2'd2; end
              default: begin
                idx_d     = 2'd0;
                upd       = 1'b1;
                pkt_d     = 1'b1;
                buttons_d = flags_q[2:0];
                click_d   = flags_q[0] & ~buttons_q[0];
              end
            endcase
          end
        end else if (idx_q != 2'd0) begin
          if (gap_q == GAP_LAST) begin
            idx_d = 2'd0; gap_d = '0; saw_aa_d = 1'b0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (wait_st) begin
      if (tmo_q != TMO_LAST) tmo_d = tmo_q + 1'b1;
      if (rx_en && rx_data == expected_rsp(state_q)) begin
        state_d = nxt;
        if (nxt == S_STREAM) retry_d = '0;
      end else if (cmd_err || tmo_hit) begin
        if (retry_q < RETRY_LAST) begin
          retry_d = retry_q + 1'b1;
          state_d = S_RST_SEND;
        end else begin
          state_d = S_ERROR;
        end
      end
    end

    if (state_d != state_q) begin
      tmo_d = '0; gap_d = '0; idx_d = 2'd0; saw_aa_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_RST_SEND;
      tmo_q      <= '0;
      gap_q      <= '0;
      retry_q    <= '0;
      idx_q      <= 2'd0;
      flags_q    <= '0;
      dxl_q      <= '0;
      saw_aa_q   <= 1'b0;
      cmd_q      <= CMD_RESET;
      cmd_send_q <= 1'b0;
      cmd_done_q <= 1'b0;
      buttons_q  <= '0;
      click_q    <= 1'b0;
      pkt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      retry_q    <= retry_d;
      idx_q      <= idx_d;
      flags_q    <= flags_d;
      dxl_q      <= dxl_d;
      saw_aa_q   <= saw_aa_d;
      cmd_q      <= cmd_d;
      cmd_send_q <= cmd_send_d;
      cmd_done_q <= cmd_done_d;
      buttons_q  <= buttons_d;
      click_q    <= click_d;
      pkt_q      <= pkt_d;
    end
  end

  ps2_axis_accum #(
    .POS_W(POS_W), .MAX(X_MAX), .INIT(X_INIT), .SHIFT(SHIFT), .INVERT(0)
  ) u_x (
    .clk_i(clock), .rst_ni(resetn), .load_i(upd), .reinit_i(reinit),
    .sign_i(flags_q[4]), .ovf_i(flags_q[6]), .low_i(dxl_q), .pos_o(x_pos)
  );

  // PS/2 reports +y as up while the screen origin is the top row.
  ps2_axis_accum #(
    .POS_W(POS_W), .MAX(Y_MAX), .INIT(Y_INIT), .SHIFT(SHIFT), .INVERT(1)
  ) u_y (
    .clk_i(clock), .rst_ni(resetn), .load_i(upd), .reinit_i(reinit),
    .sign_i(flags_q[5]), .ovf_i(flags_q[7]), .low_i(rx_data), .pos_o(y_pos)
  );

  assign cmd        = cmd_q;
  assign cmd_send   = cmd_send_q;
  assign buttons    = buttons_q;
  assign left_click = click_q;
  assign pkt_valid  = pkt_q;
  assign ready      = (state_q == S_STREAM);
  assign init_error = (state_q == S_ERROR);
  assign dbg_fsm    = {cmd_done_q, state_q};

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Bench for ps2_mouse_tracker: scripted init/corner packets plus random packets against an integer cursor model.
module tb_ps2_mouse_tracker;

  localparam int X_MAX = 159, Y_MAX = 119, X_INIT = 80, Y_INIT = 60;
  localparam int POS_W = 8, SHIFT = 0, ACK_TO = 200, GAP_TO = 40, MAX_RETRY = 3;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_en = 1'b0, cmd_sent = 1'b0, cmd_err = 1'b0;
  logic [7:0] cmd;
  logic       cmd_send, left_click, pkt_valid, ready, init_error;
  logic [POS_W-1:0] x_pos, y_pos;
  logic [2:0] buttons;
  logic [3:0] dbg_fsm;

  int n_cmp = 0, n_fail = 0;
  logic [19:0] exp_q[$];
  logic [7:0]  cmd_exp_q[$];
  logic [19:0] mon_e;
  logic [7:0]  mon_c;
  int          m_x, m_y;
  logic [2:0]  m_btn;

  ps2_mouse_tracker #(
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_INIT(X_INIT), .Y_INIT(Y_INIT), .POS_W(POS_W),
    .SHIFT(SHIFT), .ACK_TIMEOUT(ACK_TO), .GAP_TIMEOUT(GAP_TO), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clock(clock), .resetn(resetn), .rx_data(rx_data), .rx_en(rx_en),
    .cmd_sent(cmd_sent), .cmd_err(cmd_err), .cmd(cmd), .cmd_send(cmd_send),
    .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons), .left_click(left_click),
    .pkt_valid(pkt_valid), .ready(ready), .init_error(init_error), .dbg_fsm(dbg_fsm)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference model: integer cursor arithmetic straight from the packet rules.
  task automatic model_pkt(input logic [7:0] f, input logic [7:0] bx, input logic [7:0] by);
    int dx, dy;
    logic clk_l;
    dx = f[4] ? int'(bx) - 256 : int'(bx);
    dy = f[5] ? int'(by) - 256 : int'(by);
    dx = f[6] ? 0 : (dx >>> SHIFT);
    dy = f[7] ? 0 : (dy >>> SHIFT);
    m_x = m_x + dx;
    m_y = m_y - dy;
    if (m_x < 0) m_x = 0;
    if (m_x > X_MAX) m_x = X_MAX;
    if (m_y < 0) m_y = 0;
    if (m_y > Y_MAX) m_y = Y_MAX;
    clk_l = f[0] & ~m_btn[0];
    m_btn = f[2:0];
    exp_q.push_back({m_x[7:0], m_y[7:0], m_btn, clk_l});
  endtask

  task automatic model_reinit();
    m_x = X_INIT; m_y = Y_INIT; m_btn = 3'b000;
  endtask

  // Monitors: pop expectations whenever the DUT presents a packet or a command.
  always @(negedge clock) begin
    if (resetn && pkt_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pkt", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pkt_x", int'(x_pos), int'(mon_e[19:12]));
        check("pkt_y", int'(y_pos), int'(mon_e[11:4]));
        check("pkt_buttons", int'(buttons), int'(mon_e[3:1]));
        check("pkt_left_click", int'(left_click), int'(mon_e[0]));
      end
    end
  end

  always @(negedge clock) begin
    if (resetn && cmd_send) begin
      if (cmd_exp_q.size() == 0) begin
        check("unexpected_cmd", 1, 0);
      end else begin
        mon_c = cmd_exp_q.pop_front();
        check("cmd_byte", int'(cmd), int'(mon_c));
      end
    end
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b, input int idle);
    @(negedge clock);
    rx_data = b;
    rx_en   = 1'b1;
    @(negedge clock);
    rx_en   = 1'b0;
    repeat (idle) @(negedge clock);
  endtask

  task automatic send_pkt(input logic [7:0] f, input logic [7:0] bx, input logic [7:0] by);
    model_pkt(f, bx, by);
    send_byte(f, $urandom_range(0, 2));
    send_byte(bx, $urandom_range(0, 2));
    send_byte(by, $urandom_range(0, 2));
  endtask

  task automatic wait_cmd(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!cmd_send && k < 500);
    check(name, int'(cmd_send), 1);
    cmd_sent = 1'b1;
    @(negedge clock);
    cmd_sent = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (!ready && k < 100) begin
      @(negedge clock);
      k++;
    end
    check(name, int'(ready), 1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    rx_en  = 1'b0;
    #1;
    check("rst_x", int'(x_pos), X_INIT);
    check("rst_y", int'(y_pos), Y_INIT);
    check("rst_buttons", int'(buttons), 0);
    check("rst_left_click", int'(left_click), 0);
    check("rst_pkt_valid", int'(pkt_valid), 0);
    check("rst_cmd", int'(cmd), 8'hFF);
    check("rst_cmd_send", int'(cmd_send), 0);
    check("rst_ready", int'(ready), 0);
    check("rst_init_error", int'(init_error), 0);
    repeat (3) @(negedge clock);
    model_reinit();
    cmd_exp_q.push_back(8'hFF);
    resetn = 1'b1;
  endtask

  task automatic do_init();
    wait_cmd("init_ff_sent");
    send_byte(8'hFA, 1);
    send_byte(8'hAA, 1);
    cmd_exp_q.push_back(8'hF4);
    send_byte(8'h00, 0);
    wait_cmd("init_f4_sent");
    send_byte(8'hFA, 0);
    wait_ready("init_ready");
    check("init_x", int'(x_pos), X_INIT);
    check("init_y", int'(y_pos), Y_INIT);
  endtask

  // Main sequence
  initial begin
    logic [7:0] f;
    int k;
    model_reinit();
    do_reset();
    do_init();

    // First packet with explicit one-cycle latency check.
    model_pkt(8'h08, 8'h05, 8'h03);
    send_byte(8'h08, 1);
    send_byte(8'h05, 1);
    send_byte(8'h03, 0);
    check("pkt_latency", int'(pkt_valid), 1);

    // Clamp and overflow corners.
    send_pkt(8'h18, 8'hB2, 8'h00);
    send_pkt(8'h19, 8'hFB, 8'h00);
    send_pkt(8'h28, 8'h00, 8'h80);
    send_pkt(8'h48, 8'hFF, 8'h00);
    send_pkt(8'h88, 8'h10, 8'h7F);

    // Button level and left-click edge.
    send_pkt(8'h09, 8'h00, 8'h00);
    send_pkt(8'h09, 8'h00, 8'h00);
    send_pkt(8'h08, 8'h00, 8'h00);
    send_pkt(8'h0E, 8'h03, 8'hFD);

    // Desync: byte without bit3 at index 0 is dropped.
    send_byte(8'h00, 1);
    send_pkt(8'h08, 8'h01, 8'h01);

    // Mid-packet gap discards the partial packet.
    send_byte(8'h08, 0);
    send_byte(8'h01, GAP_TO + 10);
    send_pkt(8'h08, 8'h02, 8'h02);

    for (int i = 0; i < 40; i++) begin
      f = 8'($urandom_range(0, 255)) | 8'h08;
      if (f == 8'hAA) f = 8'h08;
      send_pkt(f, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    // Hot-plug: AA then 00 re-enables streaming and recentres the cursor.
    send_byte(8'hAA, 1);
    cmd_exp_q.push_back(8'hF4);
    send_byte(8'h00, 0);
    wait_cmd("hotplug_f4_sent");
    model_reinit();
    send_byte(8'hFA, 0);
    wait_ready("hotplug_ready");
    check("hotplug_x", int'(x_pos), X_INIT);
    check("hotplug_y", int'(y_pos), Y_INIT);
    check("hotplug_buttons", int'(buttons), 0);
    send_pkt(8'h09, 8'h05, 8'h03);

    // No responses at all: three reset attempts, then sticky error.
    do_reset();
    cmd_exp_q.push_back(8'hFF);
    cmd_exp_q.push_back(8'hFF);
    k = 0;
    while (!init_error && k < 3000) begin
      @(negedge clock);
      k++;
    end
    check("err_init_error", int'(init_error), 1);
    check("err_ready", int'(ready), 0);
    check("err_ff_count_left", cmd_exp_q.size(), 0);
    repeat (ACK_TO + 20) @(negedge clock);
    check("err_sticky", int'(init_error), 1);
    check("err_x_frozen", int'(x_pos), X_INIT);

    // Reset in the middle of a packet drops the partial bytes.
    do_reset();
    do_init();
    send_byte(8'h08, 0);
    send_byte(8'h07, 0);
    do_reset();
    do_init();
    send_pkt(8'h08, 8'h05, 8'h03);

    repeat (5) @(negedge clock);
    check("pkt_queue_drained", exp_q.size(), 0);
    check("cmd_queue_drained", cmd_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
